vgroup_wb_collector: RTL and testbench

- Writeback-side counterpart of the LMUL grouping issue logic.
- The issue side splits one grouped vector instruction into LMUL micro-ops. Micro-op i targets vector register rdest+i.
- This block collects those micro-op writebacks in order, forwards each as a registered vregfile write, and checks each destination index.
- Once all LMUL parts have retired, it raises one group-done handshake toward the scoreboard/commit logic.
- It sits between the ALU writeback stage and the vregfile write port.

---
 rtl/vgroup_pkg.sv | 29 ++
 rtl/vgroup_wb_collector.sv | 93 +++++++++
 tb/tb_vgroup_wb_collector.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/vgroup_pkg.sv
// Shared LMUL grouping definitions used by both the issue-side splitter and
// the writeback-side collector.
package vgroup_pkg;

    localparam int REG_W_DEF = 5;

    localparam logic [2:0] LMUL_1 = 3'b000;
    localparam logic [2:0] LMUL_2 = 3'b001;
    localparam logic [2:0] LMUL_4 = 3'b010;
    localparam logic [2:0] LMUL_8 = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DONE
    } state_t;

    // Number of micro-ops for an encoded LMUL; 0 marks an invalid code.
    function automatic logic [3:0] lmul_count(input logic [2:0] code);
        case (code)
            LMUL_1:  return 4'd1;
            LMUL_2:  return 4'd2;
            LMUL_4:  return 4'd4;
            LMUL_8:  return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/vgroup_wb_collector.sv
// Collects the in-order writebacks of one LMUL-grouped vector instruction,
// forwards them to the vregfile and signals group completion to commit.
module vgroup_wb_collector
    import vgroup_pkg::*;
#(
    parameter int MAX_LMUL = 8,
    parameter int REG_W    = REG_W_DEF,
    localparam int IDX_W   = $clog2(MAX_LMUL),
    localparam int CNT_W   = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             grp_start_valid,
    output logic             grp_start_ready,
    input  logic [2:0]       grp_lmul,
    input  logic [REG_W-1:0] grp_rdest_base,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [REG_W-1:0] wb_rdest,
    output logic             vrf_we,
    output logic [REG_W-1:0] vrf_waddr,
    output logic [IDX_W-1:0] uop_idx,
    output logic             done_valid,
    input  logic             done_ready,
    output logic [REG_W-1:0] done_rdest_base,
    output logic [2:0]       done_lmul,
    output logic             err
);

    state_t           state;
    logic [REG_W-1:0] base;
    logic [2:0]       lmul_q;
    logic [CNT_W-1:0] count;
    logic [3:0]       dec_count;
    logic [REG_W-1:0] exp_addr;
    logic             hit;
    logic             last;
    logic             start_ok;
    logic             start_bad;

    // In DONE the handshake with commit frees the slot in the same cycle.
    assign grp_start_ready = (state == S_IDLE) || (state == S_DONE && done_ready);
    assign wb_ready        = (state == S_COLLECT);
    assign done_valid      = (state == S_DONE);
    assign done_rdest_base = (state == S_DONE) ? base   : '0;
    assign done_lmul       = (state == S_DONE) ? lmul_q : '0;

    assign dec_count = lmul_count(grp_lmul);
    assign start_ok  = grp_start_valid && grp_start_ready && (dec_count != 4'd0);
    assign start_bad = grp_start_valid && grp_start_ready && (dec_count == 4'd0);

    assign exp_addr = base + REG_W'(uop_idx);
    assign hit      = (state == S_COLLECT) && wb_valid && (wb_rdest == exp_addr);
    assign last     = ({1'b0, uop_idx} == count - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            base      <= '0;
            lmul_q    <= '0;
            count     <= '0;
            uop_idx   <= '0;
            vrf_we    <= 1'b0;
            vrf_waddr <= '0;
            err       <= 1'b0;
        end else begin
            vrf_we <= hit;
            if (hit) vrf_waddr <= wb_rdest;
            // Any unaccepted writeback (stray or mismatched) or a bad start folds into one pulse.
            err <= (wb_valid && !hit) || start_bad;

            case (state)
                S_COLLECT: begin
                    if (hit) begin
                        uop_idx <= uop_idx + 1'b1;
                        if (last) state <= S_DONE;
                    end
                end
                S_DONE:  if (done_ready) state <= S_IDLE;
                default: ;
            endcase

            if (start_ok) begin
                base    <= grp_rdest_base;
                lmul_q  <= grp_lmul;
                count   <= CNT_W'(dec_count);
                uop_idx <= '0;
                state   <= S_COLLECT;
            end
        end
    end

endmodule

// File: tb/tb_vgroup_wb_collector.sv
// Randomised and directed checks of vgroup_wb_collector against a
// group-level reference model.
module tb_vgroup_wb_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       grp_start_valid;
    logic       grp_start_ready;
    logic [2:0] grp_lmul;
    logic [4:0] grp_rdest_base;
    logic       wb_valid;
    logic       wb_ready;
    logic [4:0] wb_rdest;
    logic       vrf_we;
    logic [4:0] vrf_waddr;
    logic [2:0] uop_idx;
    logic       done_valid;
    logic       done_ready;
    logic [4:0] done_rdest_base;
    logic [2:0] done_lmul;
    logic       err;

    always #5 clk = ~clk;

    vgroup_wb_collector #(.MAX_LMUL(8), .REG_W(5)) dut (
        .clk             (clk),
        .rst             (rst),
        .grp_start_valid (grp_start_valid),
        .grp_start_ready (grp_start_ready),
        .grp_lmul        (grp_lmul),
        .grp_rdest_base  (grp_rdest_base),
        .wb_valid        (wb_valid),
        .wb_ready        (wb_ready),
        .wb_rdest        (wb_rdest),
        .vrf_we          (vrf_we),
        .vrf_waddr       (vrf_waddr),
        .uop_idx         (uop_idx),
        .done_valid      (done_valid),
        .done_ready      (done_ready),
        .done_rdest_base (done_rdest_base),
        .done_lmul       (done_lmul),
        .err             (err)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a group is either being collected, waiting for commit, or absent.
    bit       m_collect, m_done;
    int       m_base, m_lmul, m_n, m_ret;
    bit       e_we, e_err;
    int       e_waddr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_collect = 0; m_done = 0;
        m_base = 0; m_lmul = 0; m_n = 0; m_ret = 0;
        e_we = 0; e_err = 0; e_waddr = 0;
    endtask

    function automatic bit model_start_ready();
        return (!m_collect && !m_done) || (m_done && done_ready);
    endfunction

    function automatic int model_exp_addr();
        return (m_base + m_ret) % 32;
    endfunction

    task automatic model_step();
        bit sready;
        int n;
        sready = model_start_ready();
        e_we  = 0;
        e_err = 0;
        if (wb_valid) begin
            if (m_collect && int'(wb_rdest) == model_exp_addr()) begin
                e_we    = 1;
                e_waddr = int'(wb_rdest);
                m_ret++;
                if (m_ret == m_n) begin
                    m_collect = 0;
                    m_done    = 1;
                end
            end else begin
                e_err = 1;
            end
        end else if (m_done && done_ready) begin
            m_done = 0;
        end
        if (wb_valid && m_done && done_ready && !e_we) m_done = 0;
        if (grp_start_valid && sready) begin
            n = (grp_lmul < 3'd4) ? (1 << grp_lmul) : 0;
            if (n != 0) begin
                m_base = int'(grp_rdest_base); m_lmul = int'(grp_lmul);
                m_n = n; m_ret = 0; m_collect = 1; m_done = 0;
            end else begin
                e_err = 1;
            end
        end
    endtask

    task automatic check_regs();
        chk("vrf_we", int'(vrf_we), int'(e_we));
        if (e_we) chk("vrf_waddr", int'(vrf_waddr), e_waddr);
        chk("err", int'(err), int'(e_err));
        chk("uop_idx", int'(uop_idx), m_ret % 8);
        chk("done_valid", int'(done_valid), int'(m_done));
        if (m_done) begin
            chk("done_rdest_base", int'(done_rdest_base), m_base);
            chk("done_lmul", int'(done_lmul), m_lmul);
        end
        chk("wb_ready", int'(wb_ready), int'(m_collect));
    endtask

    // Drives one cycle of inputs at the falling edge, checks the handshake
    // readies, advances the model and checks registered outputs one edge later.
    task automatic step(input bit r, input bit sv, input int lm, input int bs,
                        input bit wv, input int wd, input bit dr);
        rst = r; grp_start_valid = sv; grp_lmul = 3'(lm); grp_rdest_base = 5'(bs);
        wb_valid = wv; wb_rdest = 5'(wd); done_ready = dr;
        #1;
        if (!r) chk("grp_start_ready", int'(grp_start_ready), int'(model_start_ready()));
        if (r) model_reset();
        else model_step();
        @(negedge clk);
        check_regs();
    endtask

    task automatic idle_step(input bit dr);
        step(0, 0, 0, 0, 0, 0, dr);
    endtask

    initial begin
        model_reset();
        rst = 1; grp_start_valid = 0; grp_lmul = 0; grp_rdest_base = 0;
        wb_valid = 0; wb_rdest = 0; done_ready = 0;
        @(negedge clk);

        // 1: reset then LMUL=4 base 8
        step(1, 0, 0, 0, 0, 0, 0);
        chk("reset_start_ready", int'(grp_start_ready), 1);
        chk("reset_done_valid", int'(done_valid), 0);
        step(0, 1, 2, 8, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 8 + i, 0);
            chk("t1_waddr_lit", int'(vrf_waddr), 8 + i);
        end
        chk("t1_done_lit", int'(done_valid), 1);
        chk("t1_base_lit", int'(done_rdest_base), 8);
        idle_step(1);

        // 2: wrap-around base 30
        step(0, 1, 2, 30, 0, 0, 0);
        step(0, 0, 0, 0, 1, 30, 0);
        step(0, 0, 0, 0, 1, 31, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        chk("t2_wrap_lit", int'(vrf_we) * 100 + int'(vrf_waddr), 100);
        step(0, 0, 0, 0, 1, 1, 0);
        chk("t2_done_lit", int'(done_valid), 1);
        idle_step(1);

        // 3: mismatch then correct sequence
        step(0, 1, 1, 4, 0, 0, 0);
        step(0, 0, 0, 0, 1, 6, 0);
        chk("t3_err_lit", int'(err), 1);
        chk("t3_we_lit", int'(vrf_we), 0);
        chk("t3_idx_lit", int'(uop_idx), 0);
        step(0, 0, 0, 0, 1, 4, 0);
        step(0, 0, 0, 0, 1, 5, 0);

        // 4: hold done three cycles, then handshake with a new start
        for (int i = 0; i < 3; i++) begin
            idle_step(0);
            chk("t4_hold_base_lit", int'(done_rdest_base), 4);
            chk("t4_hold_lmul_lit", int'(done_lmul), 1);
        end
        step(0, 1, 0, 2, 0, 0, 1);
        chk("t4_collect_lit", int'(wb_ready), 1);
        step(0, 0, 0, 0, 1, 2, 0);
        chk("t4_done_lit", int'(done_valid), 1);
        idle_step(1);

        // 5: invalid code and stray writeback in IDLE
        step(0, 1, 4, 9, 0, 0, 0);
        chk("t5_badcode_lit", int'(err), 1);
        idle_step(0);
        chk("t5_err_oneshot_lit", int'(err), 0);
        step(0, 0, 0, 0, 1, 3, 0);
        chk("t5_stray_lit", int'(err) * 10 + int'(vrf_we), 10);

        // 6: reset mid-group, then a full LMUL=8 group with wrap
        step(0, 1, 3, 20, 0, 0, 0);
        step(0, 0, 0, 0, 1, 20, 0);
        step(0, 0, 0, 0, 1, 21, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        chk("t6_rst_idx_lit", int'(uop_idx), 0);
        chk("t6_rst_done_lit", int'(done_valid), 0);
        step(0, 1, 3, 28, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 1, (28 + i) % 32, 0);
        chk("t6_done_base_lit", int'(done_rdest_base), 28);
        idle_step(1);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            bit r, sv, wv, dr;
            int lm, bs, wd;
            r  = ($urandom_range(0, 199) == 0);
            sv = ($urandom_range(0, 9) < 3);
            lm = $urandom_range(0, 9);
            if (lm > 7) lm = $urandom_range(0, 3);
            bs = $urandom_range(0, 31);
            wv = ($urandom_range(0, 9) < 6);
            wd = (m_collect && $urandom_range(0, 9) < 8) ? model_exp_addr() : $urandom_range(0, 31);
            dr = $urandom_range(0, 1);
            step(r, sv, lm, bs, wv, wd, dr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
